// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// command-to-transaction master state encoding.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } mst_state_t;

endpackage

// File: rtl/axi4lite_mst.sv
// Single-outstanding AXI4-Lite master: converts one register command at a time
// into an AXI4-Lite write or read and reports the raw response.
module axi4lite_mst
    import axi4lite_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int AXI_AWIDTH = CFG_AWIDTH + $clog2(CFG_DWIDTH / 8)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [CFG_AWIDTH-1:0]   cmd_addr,
    input  logic [CFG_DWIDTH-1:0]   cmd_data,
    output logic                    rsp_valid,
    output logic [CFG_DWIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic [AXI_AWIDTH-1:0]   axi_awaddr,
    output logic [2:0]              axi_awprot,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [CFG_DWIDTH-1:0]   axi_wdata,
    output logic [CFG_DWIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [AXI_AWIDTH-1:0]   axi_araddr,
    output logic [2:0]              axi_arprot,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [CFG_DWIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);

    localparam int BSH    = $clog2(CFG_DWIDTH / 8);
    localparam int STRB_W = CFG_DWIDTH / 8;

    mst_state_t state_r;
    logic       aw_done_r;
    logic       w_done_r;
    logic       aw_done_s;
    logic       w_done_s;

    // Handshake completion including the one happening on the coming edge.
    always_comb begin
        aw_done_s = aw_done_r | (axi_awvalid & axi_awready);
        w_done_s  = w_done_r  | (axi_wvalid  & axi_wready);
    end

    // Transaction FSM with all interface outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= {CFG_DWIDTH{1'b0}};
            rsp_resp    <= 2'b00;
            axi_awaddr  <= {AXI_AWIDTH{1'b0}};
            axi_awprot  <= 3'b000;
            axi_awvalid <= 1'b0;
            axi_wdata   <= {CFG_DWIDTH{1'b0}};
            axi_wstrb   <= {STRB_W{1'b0}};
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_araddr  <= {AXI_AWIDTH{1'b0}};
            axi_arprot  <= 3'b000;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_wr) begin
                            axi_awaddr  <= {cmd_addr, {BSH{1'b0}}};
                            axi_awprot  <= AXPROT_DEFAULT;
                            axi_wdata   <= cmd_data;
                            axi_wstrb   <= {STRB_W{1'b1}};
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done_r   <= 1'b0;
                            w_done_r    <= 1'b0;
                            state_r     <= WADDR;
                        end else begin
                            axi_araddr  <= {cmd_addr, {BSH{1'b0}}};
                            axi_arprot  <= AXPROT_DEFAULT;
                            axi_arvalid <= 1'b1;
                            state_r     <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // Address and data channels complete independently, in any order.
                    if (axi_awvalid && axi_awready) begin
                        axi_awvalid <= 1'b0;
                    end
                    if (axi_wvalid && axi_wready) begin
                        axi_wvalid <= 1'b0;
                    end
                    aw_done_r <= aw_done_s;
                    w_done_r  <= w_done_s;
                    if (aw_done_s && w_done_s) begin
                        axi_bready <= 1'b1;
                        state_r    <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        rsp_resp   <= axi_bresp;
                        rsp_data   <= {CFG_DWIDTH{1'b0}};
                        rsp_valid  <= 1'b1;
                        cmd_ready  <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                RADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state_r     <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        rsp_data   <= axi_rdata;
                        rsp_resp   <= axi_rresp;
                        rsp_valid  <= 1'b1;
                        cmd_ready  <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    axi_awvalid <= 1'b0;
                    axi_wvalid  <= 1'b0;
                    axi_bready  <= 1'b0;
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b0;
                    cmd_ready   <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_mst.sv
// Directed and randomized bench for axi4lite_mst with a cycle-counting slave
// and a word-addressed reference memory.
module tb_axi4lite_mst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [6:0]  axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready = 1'b0;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic [6:0]  axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready = 1'b0;
    logic [31:0] axi_rdata = 32'd0;
    logic [1:0]  axi_rresp = 2'b00;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;

    int checks = 0;
    int failures = 0;
    bit bvalid_stuck = 1'b0;
    logic [31:0] ref_mem [32];
    logic [31:0] slave_mem [32];

    axi4lite_mst #(.CFG_DWIDTH(32), .CFG_AWIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int aw_w,
                            input int w_w, input int b_w, input logic [1:0] br);
        int m;
        int lat;
        int aw_hs;
        int w_hs;
        logic [6:0]  cap_addr;
        logic [31:0] cap_data;
        m   = (aw_w > w_w) ? aw_w : w_w;
        lat = m + 3 + (bvalid_stuck ? 0 : b_w);
        aw_hs = 0;
        w_hs  = 0;
        cap_addr = 7'd0;
        cap_data = 32'd0;
        axi_bresp = br;
        chk("wr_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_data = d;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("wr_awvalid", 64'(axi_awvalid), 64'(k <= aw_w + 1));
            chk("wr_wvalid", 64'(axi_wvalid), 64'(k <= w_w + 1));
            if (k <= aw_w + 1) begin
                chk("wr_awaddr", 64'(axi_awaddr), 64'({a, 2'b00}));
                chk("wr_awprot", 64'(axi_awprot), 64'(3'b000));
            end
            if (k <= w_w + 1) begin
                chk("wr_wdata", 64'(axi_wdata), 64'(d));
                chk("wr_wstrb", 64'(axi_wstrb), 64'(4'hF));
            end
            chk("wr_bready", 64'(axi_bready), 64'(k >= m + 2 && k < lat));
            chk("wr_rsp_valid", 64'(rsp_valid), 64'(k == lat));
            chk("wr_cmd_ready_busy", 64'(cmd_ready), 64'(k == lat));
            if (k < lat) begin
                axi_awready = (k > aw_w);
                axi_wready  = (k > w_w);
                axi_bvalid  = bvalid_stuck || (k == lat - 1);
                if (axi_awvalid && axi_awready) begin aw_hs++; cap_addr = axi_awaddr; end
                if (axi_wvalid && axi_wready) begin w_hs++; cap_data = axi_wdata; end
            end else begin
                axi_awready = 1'b0;
                axi_wready  = 1'b0;
                axi_bvalid  = bvalid_stuck;
                chk("wr_rsp_resp", 64'(rsp_resp), 64'(br));
                chk("wr_rsp_data", 64'(rsp_data), 64'(32'd0));
            end
        end
        chk("wr_aw_handshakes", 64'(aw_hs), 64'(1));
        chk("wr_w_handshakes", 64'(w_hs), 64'(1));
        slave_mem[cap_addr[6:2]] = cap_data;
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [4:0] a, input int ar_w, input int r_w,
                           input logic [1:0] rr);
        int lat;
        logic [6:0] cap_addr;
        lat = ar_w + r_w + 3;
        cap_addr = 7'd0;
        axi_bresp = 2'b11;
        chk("rd_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_data = 32'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("rd_arvalid", 64'(axi_arvalid), 64'(k <= ar_w + 1));
            if (k <= ar_w + 1) begin
                chk("rd_araddr", 64'(axi_araddr), 64'({a, 2'b00}));
                chk("rd_arprot", 64'(axi_arprot), 64'(3'b000));
            end
            chk("rd_rready", 64'(axi_rready), 64'(k >= ar_w + 2 && k < lat));
            chk("rd_rsp_valid", 64'(rsp_valid), 64'(k == lat));
            chk("rd_awvalid_idle", 64'(axi_awvalid), 64'(1'b0));
            if (k < lat) begin
                axi_arready = (k > ar_w);
                axi_bvalid  = bvalid_stuck;
                if (axi_arvalid && axi_arready) cap_addr = axi_araddr;
                axi_rvalid = (k == lat - 1);
                axi_rdata  = axi_rvalid ? slave_mem[cap_addr[6:2]] : 32'($urandom);
                axi_rresp  = axi_rvalid ? rr : 2'($urandom);
            end else begin
                axi_arready = 1'b0;
                axi_rvalid  = 1'b0;
                chk("rd_rsp_data", 64'(rsp_data), 64'(ref_mem[a]));
                chk("rd_rsp_resp", 64'(rsp_resp), 64'(rr));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 32'd0;
            slave_mem[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(32'd0));
        chk("rst_rsp_resp", 64'(rsp_resp), 64'(2'b00));
        chk("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid}), 64'(3'b000));
        chk("rst_readies", 64'({axi_bready, axi_rready}), 64'(2'b00));
        chk("rst_awaddr", 64'(axi_awaddr), 64'(7'd0));
        chk("rst_araddr", 64'(axi_araddr), 64'(7'd0));
        chk("rst_wdata", 64'(axi_wdata), 64'(32'd0));
        chk("rst_wstrb", 64'(axi_wstrb), 64'(4'h0));
        rst = 1'b0;

        do_write(5'h03, 32'hDEADBEEF, 0, 0, 0, 2'b00);
        do_write(5'h07, 32'h0BADF00D, 2, 0, 0, 2'b00);
        do_write(5'h1F, 32'h12345678, 0, 2, 1, 2'b01);
        do_read(5'h1F, 0, 4, 2'b10);
        do_read(5'h03, 0, 0, 2'b00);
        // Back-to-back write then read of the same register.
        do_write(5'h02, 32'hA5A5A5A5, 0, 0, 0, 2'b00);
        do_read(5'h02, 1, 0, 2'b00);

        bvalid_stuck = 1'b1;
        axi_bvalid = 1'b1;
        do_read(5'h07, 0, 2, 2'b00);
        do_write(5'h09, 32'hCAFE0001, 1, 3, 0, 2'b10);
        bvalid_stuck = 1'b0;
        axi_bvalid = 1'b0;

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(5'($urandom), 32'($urandom), int'($urandom_range(3, 0)),
                         int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 2'($urandom));
            else
                do_read(5'($urandom), int'($urandom_range(3, 0)),
                        int'($urandom_range(3, 0)), 2'($urandom));
        end

        // Reset while waiting for read data.
        chk("rr_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'h05;
        @(negedge clk);
        cmd_valid = 1'b0;
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        chk("rr_rready_before", 64'(axi_rready), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("rr_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid}), 64'(3'b000));
        chk("rr_readies", 64'({axi_bready, axi_rready}), 64'(2'b00));
        chk("rr_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rr_rsp_data", 64'(rsp_data), 64'(32'd0));
        @(negedge clk);
        rst = 1'b0;
        do_write(5'h11, 32'h5A5A0FF0, 0, 0, 0, 2'b00);
        do_read(5'h11, 0, 0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
